fifo_axis_reader: RTL
=====================

// Module: fifo_axis_reader
// PURPOSE
//  Read-side drain for the util FIFO: pops words through its rd_en/empty/dout port and presents them
//  as an AXI-Stream master (tvalid/tready/tdata/tlast) toward the DMA/PS side.
//  Absorbs the FIFO's one-cycle registered read latency with a 2-entry buffer, so it sustains one beat/cycle.
//  Marks tlast every BURST_LEN beats.
// PARAMETERS
//  BITLEN     64  data word width; matches the FIFO word width
//  BURST_LEN  16  beats per burst; tlast asserts on the last beat (must be >= 2)
//  CNT_BIT    4   beat counter width, = clog2(BURST_LEN)
// PORTS
//  clk          in   1       single clock; all logic on posedge
//  rst_n        in   1       reset, asynchronous, active-low
//  en           in   1       1 = issue FIFO reads; 0 = stop new reads, drain in-flight/buffered words
//  fifo_rd_en   out  1       pop request to the FIFO
//  fifo_empty   in   1       FIFO empty flag
//  fifo_dout    in   BITLEN  FIFO read data, valid the cycle after an accepted pop
//  m_tdata      out  BITLEN  stream data
//  m_tvalid     out  1       stream valid
//  m_tready     in   1       stream ready from the sink
//  m_tlast      out  1       last beat of a BURST_LEN burst
//  burst_done   out  1       one-cycle pulse after each tlast handshake
// BEHAVIOUR
//  Reset (async, rst_n=0): m_tvalid=0, m_tdata=0, m_tlast=0, burst_done=0, fifo_rd_en=0.
//   Clears buffer occupancy (occ=0), pending=0 and beat_cnt=0. Any word in flight is discarded.
//  Pop accounting:
//   - fifo_rd_en = en & ~fifo_empty & (occ + pending - pop < 2), where pop = m_tvalid & m_tready.
//   - The m_tready->fifo_rd_en combinational path is intended.
//   - pending <= fifo_rd_en. When pending=1, fifo_dout is written into the buffer tail at that edge.
//  Buffer: 2 entries, FIFO order, occ in 0..2, never overflows.
//   - Simultaneous write+pop: occ unchanged.
//   - Write into empty buffer: the word becomes head at the next cycle.
//  Output:
//   - m_tvalid = (occ != 0); m_tdata = head entry.
//   - tdata and tlast stay stable while tvalid=1 and tready=0.
//  Latency: fifo_rd_en in cycle 0 -> m_tvalid=1 with that word in cycle 2.
//   - Steady state (FIFO non-empty, tready=1): one beat per cycle, no bubbles.
//  Beat counter:
//   - beat_cnt increments on each handshake.
//   - m_tlast = m_tvalid & (beat_cnt == BURST_LEN-1).
//   - On the tlast handshake, beat_cnt wraps to 0 and burst_done=1 the next cycle.
//  en=0 mid-stream: no new fifo_rd_en; the pending word and buffered words still drain normally.
//   - beat_cnt is not cleared by en.
//  fifo_empty=1: no pop. m_tvalid drops once the buffer drains; the burst resumes mid-count later.
//  tready=0 with buffer full: fifo_rd_en=0; no data lost or duplicated.
// STRUCTURE
//  Shared package util_pkg:
//   - default BITLEN=64 and BURST_LEN=16
//   - clog2 function for CNT_BIT
//   - AXIS port-width constants shared with util_FIFO users
//  Sub-module util_skid2: 2-entry FIFO-ordered register buffer.
//   - ports: wr, din, pop, dout, occ[1:0]
//   - async active-low reset
//  Top-level keeps the pending flag, credit compare, beat counter and burst_done.
// TESTING
//  1 Assert rst_n=0 mid-run -> next sample shows m_tvalid=0, fifo_rd_en=0, burst_done=0.
//    After release, the next tlast comes on beat 16.
//  2 FIFO preloaded with 0x01..0x20, en=1, tready=1 -> first tvalid 2 cycles after the first rd_en.
//    32 consecutive beats 0x01..0x20; tlast on 0x10 and 0x20; two burst_done pulses.
//  3 Same data, tready pattern 1,0,0,1,0,1... -> exact order 0x01..0x20, no loss or duplication.
//    tdata stable while stalled; occ never exceeds 2.
//  4 One word written every 5 cycles (FIFO mostly empty) -> isolated tvalid pulses in order.
//    beat_cnt continues across gaps; tlast on the 16th word.
//  5 en dropped right after 2 pops issued -> exactly those 2 words are emitted.
//    No further fifo_rd_en while en=0; resumes when en=1.
//  6 Buffer full, tready=0, FIFO non-empty -> fifo_rd_en held 0 until tready=1.
//    Then 1 beat/cycle with no bubble.

Source files
------------

// File: rtl/util_pkg.sv
// Shared constants and helpers for util FIFO users.
// AXIS width constants are common to every stream endpoint.
package util_pkg;

    localparam int DEF_BITLEN    = 64;
    localparam int DEF_BURST_LEN = 16;

    localparam int AXIS_TDATA_W = DEF_BITLEN;
    localparam int AXIS_TKEEP_W = DEF_BITLEN / 8;
    localparam int AXIS_TUSER_W = 1;

    typedef struct packed {
        logic [AXIS_TDATA_W-1:0] tdata;
        logic                    tlast;
    } axis_beat_t;

    // Ceiling log2, usable in parameter expressions.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < value) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/util_skid2.sv
// Two-entry FIFO-ordered register buffer.
// Entry 0 is always the head; pop shifts entry 1 forward.
module util_skid2
    import util_pkg::*;
#(
    parameter int W = DEF_BITLEN
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic [1:0]   occ
);

    logic [W-1:0] r_e0;
    logic [W-1:0] r_e1;
    logic [1:0]   r_occ;
    logic         w_pop;

    assign w_pop = pop & (r_occ != 2'd0);
    assign dout  = r_e0;
    assign occ   = r_occ;

    // Storage and occupancy update for write, pop, or both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_e0  <= '0;
            r_e1  <= '0;
            r_occ <= 2'd0;
        end else begin
            unique case ({wr, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_e0 <= din;
                    end else begin
                        r_e1 <= din;
                    end
                    if (r_occ != 2'd2) begin
                        r_occ <= r_occ + 2'd1;
                    end
                end
                2'b01: begin
                    r_e0  <= r_e1;
                    r_occ <= r_occ - 2'd1;
                end
                2'b11: begin
                    if (r_occ == 2'd1) begin
                        r_e0 <= din;
                    end else begin
                        r_e0 <= r_e1;
                        r_e1 <= din;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/fifo_axis_reader.sv
// Drains the util FIFO read port into an AXI-Stream master.
// Credit counts buffered plus in-flight words so the buffer never overflows.
module fifo_axis_reader
    import util_pkg::*;
#(
    parameter int BITLEN    = DEF_BITLEN,
    parameter int BURST_LEN = DEF_BURST_LEN,
    parameter int CNT_BIT   = clog2(BURST_LEN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic              fifo_rd_en,
    input  logic              fifo_empty,
    input  logic [BITLEN-1:0] fifo_dout,
    output logic [BITLEN-1:0] m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast,
    output logic              burst_done
);

    logic               r_pending;
    logic [CNT_BIT-1:0] r_beat_cnt;
    logic               r_burst_done;
    logic [1:0]         w_occ;
    logic               w_pop;
    logic               w_last;
    logic [2:0]         w_credit;

    assign w_pop    = m_tvalid & m_tready;
    assign w_credit = {1'b0, w_occ}
                    + {2'b00, r_pending}
                    - {2'b00, w_pop};

    // Reset gate keeps the pop request low while held in reset.
    assign fifo_rd_en = rst_n & en & ~fifo_empty
                      & (w_credit < 3'd2);

    assign m_tvalid   = (w_occ != 2'd0);
    assign w_last     = (r_beat_cnt == CNT_BIT'(BURST_LEN - 1));
    assign m_tlast    = m_tvalid & w_last;
    assign burst_done = r_burst_done;

    // Track the word requested last cycle; it lands this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= 1'b0;
        end else begin
            r_pending <= fifo_rd_en;
        end
    end

    // Beat position inside the burst, wraps on the tlast handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat_cnt <= '0;
        end else if (w_pop) begin
            if (w_last) begin
                r_beat_cnt <= '0;
            end else begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
            end
        end
    end

    // One-cycle pulse after each completed burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_burst_done <= 1'b0;
        end else begin
            r_burst_done <= w_pop & w_last;
        end
    end

    util_skid2 #(
        .W (BITLEN)
    ) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .wr    (r_pending),
        .din   (fifo_dout),
        .pop   (w_pop),
        .dout  (m_tdata),
        .occ   (w_occ)
    );

endmodule
